servo_pwm_multi: RTL

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pkg.sv | 12 +
 rtl/servo_ch.sv | 56 +++++
 rtl/servo_pwm_multi.sv | 65 ++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: default timing constants and pulse-width clamp shared by the servo PWM block
package servo_pkg;
  localparam int DEF_PERIOD = 1_000_000;
  localparam int DEF_CNT_W = 21;
  localparam int DEF_PW_MIN = 50_000;
  localparam int DEF_PW_MAX = 250_000;
  localparam int DEF_PW_CENTER = 150_000;
  localparam int DEF_STEP = 4_000;
  function automatic int unsigned clamp(input int unsigned v, input int unsigned lo, input int unsigned hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/servo_ch.sv
// servo_ch: one servo channel holding target and active width, frame update, compare and settled flag.
// With SERVO_SLEW_EN defined the active width moves at most STEP cycles toward the target per frame.
module servo_ch
  import servo_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
`ifdef SERVO_SLEW_EN
  parameter int STEP = DEF_STEP,
`endif
  parameter int PW_CENTER = DEF_PW_CENTER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_pw,
  input  logic             i_upd,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm,
  output logic             o_settled
);
  logic [CNT_W-1:0] r_tgt, r_cur, w_next;
  logic r_en, r_pwm, r_set;
`ifdef SERVO_SLEW_EN
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);
  logic w_up;
  logic [CNT_W-1:0] w_diff;
  always_comb begin
    w_up = r_tgt > r_cur;
    w_diff = w_up ? r_tgt - r_cur : r_cur - r_tgt;
    w_next = w_diff <= STEP_W ? r_tgt : w_up ? r_cur + STEP_W : r_cur - STEP_W;
  end
`else
  assign w_next = r_tgt;
`endif
  // Width and enable change only at the frame boundary, so a pulse is never cut short.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tgt <= CNT_W'(PW_CENTER);
      r_cur <= CNT_W'(PW_CENTER);
      r_en <= 1'b0;
      r_pwm <= 1'b0;
      r_set <= 1'b1;
    end else begin
      if (i_wr) r_tgt <= i_pw;
      if (i_upd) begin
        r_cur <= w_next;
        r_en <= i_en;
      end
      r_pwm <= r_en && i_cnt < r_cur;
      r_set <= r_cur == r_tgt;
    end
  end
  assign o_pwm = r_pwm;
  assign o_settled = r_set;
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NCH-channel servo PWM with a shared frame counter and target write decode.
// Define SERVO_SLEW_EN to rate-limit active width changes to STEP cycles per frame.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PW_MIN = DEF_PW_MIN,
  parameter int PW_MAX = DEF_PW_MAX,
  parameter int PW_CENTER = DEF_PW_CENTER,
  parameter int STEP = DEF_STEP,
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_pw,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   pwm,
  output logic             frame_tick,
  output logic [NCH-1:0]   settled
);
  logic [CNT_W-1:0] r_cnt, w_pw;
  logic r_run, r_tick, w_wrap;
  if (NCH < 1 || NCH > 16 || PW_MIN > PW_CENTER || PW_CENTER > PW_MAX || PW_MAX >= PERIOD || STEP < 1 ||
      (CNT_W < 31 && (1 << CNT_W) <= PERIOD)) begin : g_bad_cfg
    $error("servo_pwm_multi: inconsistent parameters");
  end
  assign w_wrap = r_cnt == CNT_W'(PERIOD - 1);
  assign w_pw = CNT_W'(clamp(32'(wr_pw), PW_MIN, PW_MAX));
  // The first cycle after reset release is treated as cnt==0 so the frame_tick follows release directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_cnt <= w_wrap || !r_run ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap || !r_run;
    end
  end
  assign frame_tick = r_tick;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    servo_ch #(
      .CNT_W(CNT_W),
`ifdef SERVO_SLEW_EN
      .STEP(STEP),
`endif
      .PW_CENTER(PW_CENTER)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .i_wr(wr_en && wr_ch == CH_W'(i)),
      .i_pw(w_pw),
      .i_upd(w_wrap),
      .i_en(ch_en[i]),
      .i_cnt(r_cnt),
      .o_pwm(pwm[i]),
      .o_settled(settled[i])
    );
  end
endmodule
